// File: rtl/gauss_issue_if.sv
// Command, row and per-lane issue bundle between the row source and gauss_issue_ctrl.
// The slave modport is the controller side; the master modport is the row source / array observer.
interface gauss_issue_if #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N_LANE      = 8,
  parameter int ROWS_W      = 8
);
  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [OP_CODE_LEN-1:0]        cmd_op;
  logic [1:0]                    cmd_gauss_op;
  logic [ROWS_W-1:0]             cmd_rows;

  logic                          row_valid;
  logic                          row_ready;
  logic [N_LANE*GF_BIT-1:0]      row_data;

  logic [N_LANE-1:0]             start_out;
  logic [N_LANE*OP_CODE_LEN-1:0] op_out;
  logic [N_LANE*2-1:0]           gauss_op_out;
  logic [N_LANE*GF_BIT-1:0]      data_out;
  logic                          busy;
  logic                          done;

  modport master (
    output cmd_valid, cmd_op, cmd_gauss_op, cmd_rows, row_valid, row_data,
    input  cmd_ready, row_ready, start_out, op_out, gauss_op_out, data_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_gauss_op, cmd_rows, row_valid, row_data,
    output cmd_ready, row_ready, start_out, op_out, gauss_op_out, data_out, busy, done
  );
endinterface

// File: rtl/gauss_issue_ctrl.sv
// Issue-side driver for one edge of the GF systolic array: accepts a command, then streams rows.
// Define GAUSS_ISSUE_SKEW_EN for systolic skew (lane i lags lane 0 by i cycles, with a drain phase).
module gauss_issue_ctrl #(
  parameter int GF_BIT      = 4,
  parameter int OP_CODE_LEN = 4,
  parameter int N_LANE      = 8,
  parameter int ROWS_W      = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  gauss_issue_if.slave bus
);

  localparam int DCNT_W = (N_LANE > 2) ? $clog2(N_LANE) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DRAIN
  } state_e;

  state_e                 state_q, state_d;
  logic [OP_CODE_LEN-1:0] op_q, op_d;
  logic [1:0]             gop_q, gop_d;
  logic [ROWS_W-1:0]      rows_q, rows_d;
  logic [ROWS_W-1:0]      row_cnt_q, row_cnt_d;
  logic [ROWS_W-1:0]      row_cnt_inc;
  logic                   first_q, first_d;
  logic [DCNT_W-1:0]      drain_q, drain_d;
  logic                   done_q, done_d;
  logic                   issue;

  logic                   lane_start_q [N_LANE];
  logic                   lane_start_d [N_LANE];
  logic [OP_CODE_LEN-1:0] lane_op_q    [N_LANE];
  logic [OP_CODE_LEN-1:0] lane_op_d    [N_LANE];
  logic [1:0]             lane_gop_q   [N_LANE];
  logic [1:0]             lane_gop_d   [N_LANE];

  // ---------------------------------------------------------------------------
  // Command / stream sequencer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      gop_q     <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      first_q   <= 1'b0;
      drain_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      gop_q     <= gop_d;
      rows_q    <= rows_d;
      row_cnt_q <= row_cnt_d;
      first_q   <= first_d;
      drain_q   <= drain_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    gop_d       = gop_q;
    rows_d      = rows_q;
    row_cnt_d   = row_cnt_q;
    first_d     = first_q;
    drain_d     = drain_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    row_cnt_inc = row_cnt_q + ROWS_W'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          op_d      = bus.cmd_op;
          gop_d     = bus.cmd_gauss_op;
          rows_d    = bus.cmd_rows;
          row_cnt_d = '0;
          first_d   = 1'b1;
          if (bus.cmd_rows == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_STREAM;
          end
        end
      end

      ST_STREAM: begin
        if (bus.row_valid) begin
          issue     = 1'b1;
          first_d   = 1'b0;
          row_cnt_d = row_cnt_inc;
          // Equality against the latched count: the counter can never pass it and wrap.
          if (row_cnt_inc == rows_q) begin
`ifdef GAUSS_ISSUE_SKEW_EN
            state_d = ST_DRAIN;
            drain_d = DCNT_W'(N_LANE - 2);
`else
            state_d = ST_IDLE;
            done_d  = 1'b1;
`endif
          end
        end
      end

      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q - DCNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.cmd_ready = (state_q == ST_IDLE);
  assign bus.row_ready = (state_q == ST_STREAM);
  assign bus.busy      = (state_q == ST_STREAM) || (state_q == ST_DRAIN);
  assign bus.done      = done_q;

  // ---------------------------------------------------------------------------
  // Lane control chain. Lane 0 takes the issued word (NOP on a bubble); the
  // chain shifts every cycle regardless of state so bubbles and drain flush out.
  // ---------------------------------------------------------------------------
  always_comb begin
    lane_start_d[0] = issue & first_q;
    lane_op_d[0]    = issue ? op_q  : '0;
    lane_gop_d[0]   = issue ? gop_q : 2'b00;
    for (int i = 1; i < N_LANE; i++) begin
`ifdef GAUSS_ISSUE_SKEW_EN
      lane_start_d[i] = lane_start_q[i-1];
      lane_op_d[i]    = lane_op_q[i-1];
      lane_gop_d[i]   = lane_gop_q[i-1];
`else
      lane_start_d[i] = lane_start_d[0];
      lane_op_d[i]    = lane_op_d[0];
      lane_gop_d[i]   = lane_gop_d[0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_LANE; i++) begin
        lane_start_q[i] <= 1'b0;
        lane_op_q[i]    <= '0;
        lane_gop_q[i]   <= 2'b00;
      end
    end else begin
      for (int i = 0; i < N_LANE; i++) begin
        lane_start_q[i] <= lane_start_d[i];
        lane_op_q[i]    <= lane_op_d[i];
        lane_gop_q[i]   <= lane_gop_d[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-lane data: lane gi only ever shows its own slice, so each lane keeps a
  // private delay line of its slice instead of shifting the whole row.
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_LANE; gi++) begin : g_lane
`ifdef GAUSS_ISSUE_SKEW_EN
    localparam int DEPTH = gi + 1;
`else
    localparam int DEPTH = 1;
`endif
    logic [GF_BIT-1:0] dline_q [DEPTH];
    logic [GF_BIT-1:0] dline_d [DEPTH];

    always_comb begin
      dline_d[0] = issue ? bus.row_data[gi*GF_BIT +: GF_BIT] : '0;
      for (int j = 1; j < DEPTH; j++) begin
        dline_d[j] = dline_q[j-1];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int j = 0; j < DEPTH; j++) begin
          dline_q[j] <= '0;
        end
      end else begin
        for (int j = 0; j < DEPTH; j++) begin
          dline_q[j] <= dline_d[j];
        end
      end
    end

    assign bus.start_out[gi]                               = lane_start_q[gi];
    assign bus.op_out[gi*OP_CODE_LEN +: OP_CODE_LEN]       = lane_op_q[gi];
    assign bus.gauss_op_out[gi*2 +: 2]                     = lane_gop_q[gi];
    assign bus.data_out[gi*GF_BIT +: GF_BIT]               = dline_q[DEPTH-1];
  end

endmodule

// File: tb/tb_gauss_issue_ctrl.sv
// Directed bench for gauss_issue_ctrl (N_LANE=4, GF_BIT=4); expectations follow the
// GAUSS_ISSUE_SKEW_EN setting of the build.
module tb_gauss_issue_ctrl;

  localparam int NL = 4;
`ifdef GAUSS_ISSUE_SKEW_EN
  localparam bit SKEW = 1'b1;
`else
  localparam bit SKEW = 1'b0;
`endif
  localparam int DR = SKEW ? NL - 1 : 0;

  logic clk;
  logic rst_n;

  gauss_issue_if #(.GF_BIT(4), .OP_CODE_LEN(4), .N_LANE(NL), .ROWS_W(8)) bus ();

  gauss_issue_ctrl #(.GF_BIT(4), .OP_CODE_LEN(4), .N_LANE(NL), .ROWS_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  int cyc;

  int          cmd_cyc;
  int          nbeats;
  int          acc_cyc [8];
  logic [15:0] beat_d  [8];
  logic [3:0]  cur_op;
  logic [1:0]  cur_gop;

  logic [3:0]  log_s  [512];
  logic [15:0] log_o  [512];
  logic [7:0]  log_g  [512];
  logic [15:0] log_d  [512];
  logic        log_busy [512];
  logic        log_done [512];
  logic        log_rr   [512];
  logic        log_cr   [512];

  function automatic logic [8:0] idx(input int t);
    return t[8:0];
  endfunction

  // Outputs are logged mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    log_s[idx(cyc)]    <= bus.start_out;
    log_o[idx(cyc)]    <= bus.op_out;
    log_g[idx(cyc)]    <= bus.gauss_op_out;
    log_d[idx(cyc)]    <= bus.data_out;
    log_busy[idx(cyc)] <= bus.busy;
    log_done[idx(cyc)] <= bus.done;
    log_rr[idx(cyc)]   <= bus.row_ready;
    log_cr[idx(cyc)]   <= bus.cmd_ready;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic int lat(input int i);
    return SKEW ? i + 1 : 1;
  endfunction

  // Expected lane outputs in cycle t from the beats the bench itself issued.
  function automatic void exp_lanes(input int t, output logic [3:0] s, output logic [15:0] o,
                                    output logic [7:0] g, output logic [15:0] d);
    logic [15:0] bd;
    s = '0; o = '0; g = '0; d = '0;
    for (int i = 0; i < NL; i++) begin
      for (int k = 0; k < nbeats; k++) begin
        if (acc_cyc[k] + lat(i) == t) begin
          bd          = beat_d[k];
          s[i]        = (k == 0);
          o[i*4 +: 4] = cur_op;
          g[i*2 +: 2] = cur_gop;
          d[i*4 +: 4] = bd[i*4 +: 4];
        end
      end
    end
  endfunction

  task automatic drive_cmd(input logic [3:0] op, input logic [1:0] gop, input int rows,
                           input logic [15:0] pat, input bit noise, input int extra);
    int k;
    nbeats           = 0;
    cur_op           = op;
    cur_gop          = gop;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = op;
    bus.cmd_gauss_op = gop;
    bus.cmd_rows     = 8'(rows);
    cmd_cyc          = cyc;
    $display("cmd op=%h gauss_op=%b rows=%0d pattern=%b cycle=%0d", op, gop, rows, pat, cyc);
    tick();
    bus.cmd_valid = 1'b0;
    k = 0;
    while (nbeats < rows && k < 64) begin
      bus.cmd_valid = noise;
      bus.row_valid = pat[k % 16];
      bus.row_data  = pat[k % 16] ? beat_d[nbeats] : 16'hDEAD;
      if (pat[k % 16]) begin
        acc_cyc[nbeats] = cyc;
        nbeats++;
      end
      k++;
      tick();
    end
    bus.cmd_valid = 1'b0;
    bus.row_valid = 1'b0;
    bus.row_data  = 16'h0000;
    repeat (extra) tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++; if (bus.start_out !== 4'h0) begin errors++; $display("FAIL reset_start: got %h want 0", bus.start_out); end
    checks++; if (bus.op_out !== 16'h0) begin errors++; $display("FAIL reset_op: got %h want 0", bus.op_out); end
    checks++; if (bus.gauss_op_out !== 8'h0) begin errors++; $display("FAIL reset_gop: got %h want 0", bus.gauss_op_out); end
    checks++; if (bus.data_out !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.data_out); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.row_ready !== 1'b0) begin errors++; $display("FAIL reset_row_ready: got %b want 0", bus.row_ready); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.done); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int a, t, cnt, dcnt;
    logic [15:0] dv;
    beat_d[0] = 16'h4321;
    drive_cmd(4'h7, 2'b00, 1, 16'hFFFF, 1'b0, NL + 3);
    a = acc_cyc[0];
    for (int i = 0; i < NL; i++) begin
      t  = a + lat(i);
      dv = log_d[idx(t)];
      checks++; if (dv[i*4 +: 4] !== 4'(i + 1)) begin errors++; $display("FAIL single_data lane%0d: got %h want %h", i, dv[i*4 +: 4], 4'(i + 1)); end
      checks++; if (log_s[idx(t)][i] !== 1'b1) begin errors++; $display("FAIL single_start lane%0d: got %b want 1", i, log_s[idx(t)][i]); end
      dv = log_o[idx(t)];
      checks++; if (dv[i*4 +: 4] !== 4'h7) begin errors++; $display("FAIL single_op lane%0d: got %h want 7", i, dv[i*4 +: 4]); end
      cnt = 0;
      for (int u = cmd_cyc; u <= a + NL + 2; u++) cnt += int'(log_s[idx(u)][i]);
      checks++; if (cnt !== 1) begin errors++; $display("FAIL single_start_count lane%0d: got %0d want 1", i, cnt); end
    end
    dcnt = 0;
    for (int u = cmd_cyc; u <= a + NL + 2; u++) dcnt += int'(log_done[idx(u)]);
    checks++; if (log_done[idx(a + 1 + DR)] !== 1'b1) begin errors++; $display("FAIL single_done_time: got %b want 1 at cycle %0d", log_done[idx(a + 1 + DR)], a + 1 + DR); end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", dcnt); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] es; logic [15:0] eo, ed; logic [7:0] eg;
    int last, bcnt, scnt;
    beat_d[0] = 16'hA5C3;
    beat_d[1] = 16'h3C5A;
    beat_d[2] = 16'h0F1E;
    drive_cmd(4'hB, 2'b01, 3, 16'hFFFF, 1'b1, NL + 3);
    last = acc_cyc[2];
    bcnt = 0;
    scnt = 0;
    for (int t = cmd_cyc; t <= last + NL + 2; t++) begin
      exp_lanes(t, es, eo, eg, ed);
      checks++; if ({log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)]} !== {es, eo, eg, ed}) begin
        errors++; $display("FAIL b2b_lanes cycle %0d: got s=%h o=%h g=%h d=%h want s=%h o=%h g=%h d=%h",
                           t, log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)], es, eo, eg, ed);
      end
      checks++; if (log_busy[idx(t)] !== ((t > cmd_cyc) && (t <= last + DR))) begin errors++; $display("FAIL b2b_busy cycle %0d: got %b", t, log_busy[idx(t)]); end
      checks++; if (log_done[idx(t)] !== (t == last + DR + 1)) begin errors++; $display("FAIL b2b_done cycle %0d: got %b", t, log_done[idx(t)]); end
      checks++; if (log_rr[idx(t)] !== ((t > cmd_cyc) && (t <= last))) begin errors++; $display("FAIL b2b_row_ready cycle %0d: got %b", t, log_rr[idx(t)]); end
      bcnt += int'(log_busy[idx(t)]);
      for (int i = 0; i < NL; i++) scnt += int'(log_s[idx(t)][i]);
    end
    checks++; if (bcnt !== 3 + DR) begin errors++; $display("FAIL b2b_busy_len: got %0d want %0d", bcnt, 3 + DR); end
    checks++; if (scnt !== NL) begin errors++; $display("FAIL b2b_start_total: got %0d want %0d", scnt, NL); end
  endtask

  task automatic test_bubbles();
    logic [3:0] es; logic [15:0] eo, ed; logic [7:0] eg;
    int last, dcnt, bcnt;
    beat_d[0] = 16'h9876;
    beat_d[1] = 16'h1234;
    drive_cmd(4'h3, 2'b10, 2, 16'b1001, 1'b0, NL + 3);
    last = acc_cyc[1];
    dcnt = 0;
    bcnt = 0;
    for (int t = cmd_cyc; t <= last + NL + 2; t++) begin
      exp_lanes(t, es, eo, eg, ed);
      checks++; if ({log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)]} !== {es, eo, eg, ed}) begin
        errors++; $display("FAIL bubble_lanes cycle %0d: got s=%h o=%h g=%h d=%h want s=%h o=%h g=%h d=%h",
                           t, log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)], es, eo, eg, ed);
      end
      dcnt += int'(log_done[idx(t)]);
      bcnt += int'(log_busy[idx(t)]);
    end
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL bubble_done_count: got %0d want 1", dcnt); end
    checks++; if (log_done[idx(last + DR + 1)] !== 1'b1) begin errors++; $display("FAIL bubble_done_time: got %b want 1", log_done[idx(last + DR + 1)]); end
    checks++; if (log_cr[idx(last + DR + 1)] !== 1'b1) begin errors++; $display("FAIL bubble_cmd_ready_at_done: got %b want 1", log_cr[idx(last + DR + 1)]); end
    checks++; if (bcnt !== 4 + DR) begin errors++; $display("FAIL bubble_busy_len: got %0d want %0d", bcnt, 4 + DR); end
  endtask

  task automatic test_zero_rows();
    drive_cmd(4'hC, 2'b11, 0, 16'hFFFF, 1'b0, 0);
    bus.row_valid = 1'b1;
    bus.row_data  = 16'hFFFF;
    repeat (NL + 3) tick();
    bus.row_valid = 1'b0;
    bus.row_data  = 16'h0000;
    for (int t = cmd_cyc; t < cyc; t++) begin
      checks++; if ({log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)]} !== 44'h0) begin
        errors++; $display("FAIL zero_lanes cycle %0d: got s=%h o=%h g=%h d=%h want all 0",
                           t, log_s[idx(t)], log_o[idx(t)], log_g[idx(t)], log_d[idx(t)]);
      end
      checks++; if (log_busy[idx(t)] !== 1'b0) begin errors++; $display("FAIL zero_busy cycle %0d: got %b want 0", t, log_busy[idx(t)]); end
      checks++; if (log_done[idx(t)] !== (t == cmd_cyc + 1)) begin errors++; $display("FAIL zero_done cycle %0d: got %b", t, log_done[idx(t)]); end
      checks++; if (log_rr[idx(t)] !== 1'b0) begin errors++; $display("FAIL zero_row_ready cycle %0d: got %b want 0", t, log_rr[idx(t)]); end
    end
  endtask

  task automatic test_reset_mid();
    int rc, a, dcnt;
    logic [15:0] dv;
    nbeats           = 0;
    bus.cmd_valid    = 1'b1;
    bus.cmd_op       = 4'h5;
    bus.cmd_gauss_op = 2'b11;
    bus.cmd_rows     = 8'd4;
    $display("cmd op=5 gauss_op=11 rows=4 reset after beat 1 cycle=%0d", cyc);
    tick();
    bus.cmd_valid = 1'b0;
    bus.row_valid = 1'b1;
    bus.row_data  = 16'h1111;
    tick();
    bus.row_data  = 16'h2222;
    tick();
    bus.row_valid = 1'b0;
    bus.row_data  = 16'h0000;
    rst_n = 1'b0;
    rc    = cyc;
    #1;
    checks++; if ({bus.start_out, bus.op_out, bus.gauss_op_out, bus.data_out} !== 44'h0) begin
      errors++; $display("FAIL midrst_lanes: got s=%h o=%h g=%h d=%h want all 0",
                         bus.start_out, bus.op_out, bus.gauss_op_out, bus.data_out);
    end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b want 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b want 0", bus.done); end
    checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_cmd_ready: got %b want 1", bus.cmd_ready); end
    checks++; if (bus.row_ready !== 1'b0) begin errors++; $display("FAIL midrst_row_ready: got %b want 0", bus.row_ready); end
    repeat (2) tick();
    rst_n     = 1'b1;
    beat_d[0] = 16'h8421;
    drive_cmd(4'h9, 2'b01, 1, 16'hFFFF, 1'b0, NL + 3);
    a = acc_cyc[0];
    checks++; if (log_rr[idx(cmd_cyc + 1)] !== 1'b1) begin errors++; $display("FAIL midrst_new_cmd_accept: got row_ready=%b want 1", log_rr[idx(cmd_cyc + 1)]); end
    dcnt = 0;
    for (int t = rc; t <= cmd_cyc; t++) dcnt += int'(log_done[idx(t)]);
    checks++; if (dcnt !== 0) begin errors++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dcnt); end
    dcnt = 0;
    for (int t = rc; t < cyc; t++) dcnt += int'(log_done[idx(t)]);
    checks++; if (dcnt !== 1) begin errors++; $display("FAIL midrst_done_count: got %0d want 1", dcnt); end
    checks++; if (log_done[idx(a + DR + 1)] !== 1'b1) begin errors++; $display("FAIL midrst_done_time: got %b want 1", log_done[idx(a + DR + 1)]); end
    dv = log_d[idx(a + lat(NL - 1))];
    checks++; if (dv[(NL-1)*4 +: 4] !== 4'h8) begin errors++; $display("FAIL midrst_lane3_data: got %h want 8", dv[(NL-1)*4 +: 4]); end
    dv = log_o[idx(a + 1)];
    checks++; if (dv[3:0] !== 4'h9) begin errors++; $display("FAIL midrst_lane0_op: got %h want 9", dv[3:0]); end
  endtask

  initial begin
    errors           = 0;
    checks           = 0;
    cyc              = 0;
    rst_n            = 1'b0;
    bus.cmd_valid    = 1'b0;
    bus.cmd_op       = 4'h0;
    bus.cmd_gauss_op = 2'b00;
    bus.cmd_rows     = 8'd0;
    bus.row_valid    = 1'b0;
    bus.row_data     = 16'h0000;
    test_reset();
    test_single();
    test_back_to_back();
    test_bubbles();
    test_zero_rows();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
